// File: rtl/mdr_mem_ctrl.sv
// MAR/MDR capture stage with a read/write handshake FSM toward external memory.
// Optional wait-state timeout compiled in with `define MDR_MEM_TIMEOUT_EN.
module mdr_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mar_load,
  input  logic                  mdr_load,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic [ADDR_WIDTH-1:0] mar_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] mar_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  expire_d;

`ifdef MDR_MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q;
  logic       err_q;

  // Counter is zero in the first strobe cycle, so TMO_LAST marks the final allowed one.
  assign expire_d = !mem_ready && (wait_cnt_q == TMO_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == IDLE) ? 8'd0 : wait_cnt_q + 8'd1;
      if (state_q != IDLE && expire_d)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic       unused_err_clr;
  logic [7:0] unused_tmo;

  assign unused_err_clr = err_clr;
  assign unused_tmo     = 8'(TIMEOUT_CYCLES);
  assign expire_d       = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      mar_q    <= '0;
      mdr_q    <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mar_load) mar_q <= bus_in[ADDR_WIDTH-1:0];
          if (mdr_load) mdr_q <= bus_in;
          if (rd_req) begin
            state_q  <= RD_WAIT;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (wr_req) begin
            state_q  <= WR_WAIT;
            mem_wr_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (mem_ready || expire_d) begin
            if (mem_ready) mdr_q <= mem_rdata;
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (mem_ready || expire_d) begin
            state_q  <= IDLE;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdr_out   = mdr_q;
  assign mar_out   = mar_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Randomized bench for mdr_mem_ctrl against a transaction-level model of MAR/MDR/err.
module tb_mdr_mem_ctrl;

  localparam int TMO = 4;
`ifdef MDR_MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] bus_in = '0;
  logic        mar_load = 1'b0, mdr_load = 1'b0, rd_req = 1'b0, wr_req = 1'b0, err_clr = 1'b0;
  logic [31:0] mdr_out, mem_wdata, mem_rdata = '0;
  logic [8:0]  mar_out, mem_addr;
  logic        mem_rd, mem_wr, mem_ready = 1'b0, busy, done, err;

  logic [8:0]  mar_m = '0;
  logic [31:0] mdr_m = '0;
  bit          err_m = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mdr_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .clear(clear), .bus_in(bus_in),
    .mar_load(mar_load), .mdr_load(mdr_load), .rd_req(rd_req), .wr_req(wr_req),
    .err_clr(err_clr), .mdr_out(mdr_out), .mar_out(mar_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input bit rd, input bit wr, input bit dn);
    check("mem_rd", 32'(mem_rd), 32'(rd));
    check("mem_wr", 32'(mem_wr), 32'(wr));
    check("busy", 32'(busy), 32'(rd | wr));
    check("done", 32'(done), 32'(dn));
    check("mar_out", 32'(mar_out), 32'(mar_m));
    check("mem_addr", 32'(mem_addr), 32'(mar_m));
    check("mdr_out", mdr_out, mdr_m);
    check("mem_wdata", mem_wdata, mdr_m);
    check("err", 32'(err), 32'(err_m));
  endtask

  // Advance one edge and apply the sticky-error rule: abort sets, otherwise err_clr clears.
  task automatic tick(input bit abort);
    @(posedge clock);
    #1;
    if (abort) err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
  endtask

  // One request cycle in IDLE, then wait cycles with memory ready after w stalls.
  // Lockout inputs are randomized while busy; the model ignores them.
  task automatic access(input bit rd, input bit wr, input bit ml, input bit dl,
                        input logic [31:0] bus, input int w, input logic [31:0] rdata);
    bit is_rd, is_wr, fin, abort;
    int k;
    logic [31:0] rdat;
    is_rd = rd;
    is_wr = !rd && wr;
    bus_in = bus; mar_load = ml; mdr_load = dl; rd_req = rd; wr_req = wr;
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    err_clr = ($urandom_range(0, 3) == 0);
    tick(1'b0);
    if (ml) mar_m = bus[8:0];
    if (dl) mdr_m = bus;
    check_all(is_rd, is_wr, 1'b0);
    if (!is_rd && !is_wr) return;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      bus_in = $urandom; mar_load = 1'($urandom_range(0, 1)); mdr_load = 1'($urandom_range(0, 1));
      rd_req = 1'($urandom_range(0, 1)); wr_req = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 3) == 0);
      mem_ready = (k == w);
      rdat = (k == w) ? rdata : $urandom;
      mem_rdata = rdat;
      abort = TMO_EN && !mem_ready && (k == TMO - 1);
      tick(abort);
      if (mem_ready) begin
        fin = 1'b1;
        if (is_rd) mdr_m = rdat;
      end else if (abort) begin
        fin = 1'b1;
      end
      if (fin) check_all(1'b0, 1'b0, 1'b1);
      else check_all(is_rd, is_wr, 1'b0);
      k++;
    end
    mar_load = 1'b0; mdr_load = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_all(1'b0, 1'b0, 1'b0);
    clear = 1'b0;

    // Zero-wait read of 0x055.
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 0, 32'hDEAD_BEEF);
    check("read_mdr", mdr_out, 32'hDEAD_BEEF);
    // Load MDR, then write to 0x1FF with three wait cycles.
    access(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 0, 32'h0);
    access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_01FF, 3, 32'hFFFF_FFFF);
    check("write_mdr_kept", mdr_out, 32'h1234_5678);
    // Both requests with a MAR load: read wins.
    access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1, 32'hA5A5_0F0F);
    check("simul_addr", 32'(mem_addr), 32'h010);

`ifdef MDR_MEM_TIMEOUT_EN
    access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 100, 32'h0);
    check("tmo_err", 32'(err), 32'h1);
    check("tmo_mdr", mdr_out, 32'hA5A5_0F0F);
    err_clr = 1'b1;
    tick(1'b0);
    err_clr = 1'b0;
    check_all(1'b0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, TMO - 1, 32'h0BAD_CAFE);
    check("last_cycle_ok", 32'(err), 32'(err_m));
`endif

    // Reset in the middle of a read.
    bus_in = 32'h0000_0123; mar_load = 1'b1; rd_req = 1'b1; mem_ready = 1'b0;
    tick(1'b0);
    mar_m = 9'h123;
    check_all(1'b1, 1'b0, 1'b0);
    mar_load = 1'b0; rd_req = 1'b0; mem_rdata = 32'h7777_7777;
    #2 clear = 1'b1;
    #1;
    mar_m = '0; mdr_m = '0; err_m = 1'b0;
    check_all(1'b0, 1'b0, 1'b0);
    tick(1'b0);
    clear = 1'b0;
    mem_ready = 1'b1;
    tick(1'b0);
    check_all(1'b0, 1'b0, 1'b0);
    tick(1'b0);
    check_all(1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;

    for (int n = 0; n < 150; n++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, $urandom_range(0, 6), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
